// File: rtl/seg7_scan_driver.sv
// Multiplexed four-digit seven-segment scan driver with a one-deep pending
// register that is copied into the display register at frame boundaries.
module seg7_scan_driver #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_bcd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic        frame_done,
  output logic        err
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] presc;
  logic [1:0]  idx;
  logic [15:0] disp;
  logic [15:0] pend;
  logic        pend_full;
  logic        tick;
  logic        boundary;
  logic [3:0]  cur_nib;
  logic        cur_blank;
  logic        disp_bad;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1110011;
      default: return 7'b0000001;
    endcase
  endfunction

  assign tick       = (presc == LAST);
  assign boundary   = tick && (idx == 2'd3);
  assign frame_done = boundary;
  assign in_ready   = !pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A full pending register blocks new input, so a handshake can never
  // coincide with the boundary copy of the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (pend_full) begin
      if (boundary) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
    end else if (in_valid) begin
      pend      <= in_bcd;
      pend_full <= 1'b1;
    end
  end

  always_comb begin
    cur_nib   = disp[3:0];
    cur_blank = 1'b0;
    case (idx)
      2'd0: cur_nib = disp[3:0];
      2'd1: cur_nib = disp[7:4];
      2'd2: cur_nib = disp[11:8];
      2'd3: cur_nib = disp[15:12];
      default: cur_nib = disp[3:0];
    endcase
    if (BLANK_LZ != 0) begin
      case (idx)
        2'd1: cur_blank = (disp[15:4] == 12'd0);
        2'd2: cur_blank = (disp[15:8] == 8'd0);
        2'd3: cur_blank = (disp[15:12] == 4'd0);
        default: cur_blank = 1'b0;
      endcase
    end
  end

  assign disp_bad = (disp[3:0] > 4'd9) || (disp[7:4] > 4'd9) ||
                    (disp[11:8] > 4'd9) || (disp[15:12] > 4'd9);

  // Outputs trail idx/disp by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg    <= '0;
      dig_en <= '0;
      err    <= 1'b0;
    end else begin
      seg    <= cur_blank ? 7'b0000000 : decode(cur_nib);
      dig_en <= 4'b0001 << idx;
      err    <= disp_bad;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: accepted values go into a scoreboard queue and
// are compared against whole captured scan frames on both blanking variants.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_bcd = '0;
  logic        in_valid = 1'b0;

  logic        in_ready, frame_done, err;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        in_ready_nb, frame_done_nb, err_nb;
  logic [6:0]  seg_nb;
  logic [3:0]  dig_en_nb;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  logic [27:0] cap_seg, cap_seg_nb;
  logic [15:0] cap_en;
  logic        cap_ready, cap_err_old, cap_err_new;
  bit          cap_ok;

  localparam logic [15:0] EN_SEQ = 16'b1000_0100_0010_0001;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .in_bcd(in_bcd), .in_valid(in_valid),
    .in_ready(in_ready), .seg(seg), .dig_en(dig_en),
    .frame_done(frame_done), .err(err)
  );

  seg7_scan_driver #(.DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .in_bcd(in_bcd), .in_valid(in_valid),
    .in_ready(in_ready_nb), .seg(seg_nb), .dig_en(dig_en_nb),
    .frame_done(frame_done_nb), .err(err_nb)
  );

  // Scoreboard producer: every accepted value is expected on a later frame.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_bcd);
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;  4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;  4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;  4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;  4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;  4'd9: return 7'b1110011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [27:0] ref_frame(input logic [15:0] v, input bit blank);
    logic [27:0] f;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && (v >> (4 * i)) == 16'd0) f[7*i +: 7] = 7'b0000000;
      else f[7*i +: 7] = ref_seg(v[4*i +: 4]);
    end
    return f;
  endfunction

  task automatic pop_expected(output logic [15:0] v, output bit ok);
    ok = (exp_q.size() != 0);
    if (ok) v = exp_q.pop_front();
    else v = 16'h0000;
  endtask

  task automatic send(input logic [15:0] v, output bit ok);
    int n;
    n = 0;
    in_bcd = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Uses the current negedge if it already shows frame_done.
  task automatic capture_frame();
    int n;
    n = 0;
    cap_ok = 1'b1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      cap_ok = 1'b0;
      return;
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cap_ready = in_ready;
        cap_err_old = err;
      end
      if (k == 2) cap_err_new = err;
      if (k % 4 == 2) begin
        cap_seg[7*(k/4) +: 7]    = seg;
        cap_seg_nb[7*(k/4) +: 7] = seg_nb;
        cap_en[4*(k/4) +: 4]     = dig_en;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, seg, dig_en, frame_done, err} !== {1'b1, 7'b0, 4'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b seg=%b en=%b fd=%b err=%b expected 1 0000000 0000 0 0",
               in_ready, seg, dig_en, frame_done, err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dig_en !== 4'b0001 || seg !== 7'b1111110 || seg_nb !== 7'b1111110) begin
      errors++;
      $display("[TB] FAIL first_digit: got en=%b seg=%b seg_nb=%b expected 0001 1111110 1111110",
               dig_en, seg, seg_nb);
    end
    n = 1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("[TB] FAIL first_frame_done: got cycle %0d expected 15", n);
    end
  endtask

  task automatic test_idle_scan();
    int n;
    capture_frame();
    checks++;
    if (!cap_ok || cap_seg !== ref_frame(16'h0000, 1'b1) || cap_en !== EN_SEQ) begin
      errors++;
      $display("[TB] FAIL idle_frame: got seg=%h en=%h expected seg=%h en=%h",
               cap_seg, cap_en, ref_frame(16'h0000, 1'b1), EN_SEQ);
    end
    checks++;
    if (!cap_ok || cap_seg_nb !== ref_frame(16'h0000, 1'b0)) begin
      errors++;
      $display("[TB] FAIL idle_frame_nb: got %h expected %h", cap_seg_nb, ref_frame(16'h0000, 1'b0));
    end
    n = 0;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n = 1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("[TB] FAIL frame_period: got %0d expected 16", n);
    end
  endtask

  task automatic test_load_digits();
    bit ok, sb_ok;
    logic [15:0] v;
    send(16'h1234, ok);
    checks++;
    if (!ok || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_accept: got ok=%b rdy=%b expected ok=1 rdy=0", ok, in_ready);
    end
    capture_frame();
    pop_expected(v, sb_ok);
    checks++;
    if (!cap_ok || !sb_ok || cap_seg !== ref_frame(v, 1'b1) || cap_en !== EN_SEQ) begin
      errors++;
      $display("[TB] FAIL load_1234: got %h expected %h", cap_seg, ref_frame(v, 1'b1));
    end
    checks++;
    if (cap_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_boundary: got %b expected 1", cap_ready);
    end
  endtask

  task automatic test_blanking();
    bit ok, sb_ok;
    logic [15:0] v;
    send(16'h0070, ok);
    capture_frame();
    pop_expected(v, sb_ok);
    checks++;
    if (!ok || !cap_ok || !sb_ok || cap_seg !== ref_frame(v, 1'b1)) begin
      errors++;
      $display("[TB] FAIL blank_0070: got %h expected %h", cap_seg, ref_frame(v, 1'b1));
    end
    checks++;
    if (!cap_ok || !sb_ok || cap_seg_nb !== ref_frame(v, 1'b0)) begin
      errors++;
      $display("[TB] FAIL noblank_0070: got %h expected %h", cap_seg_nb, ref_frame(v, 1'b0));
    end
  endtask

  task automatic test_err();
    bit ok, sb_ok;
    logic [15:0] v;
    send(16'h9A05, ok);
    capture_frame();
    pop_expected(v, sb_ok);
    checks++;
    if (!ok || !cap_ok || !sb_ok || cap_seg !== ref_frame(v, 1'b1)) begin
      errors++;
      $display("[TB] FAIL dash_9a05: got %h expected %h", cap_seg, ref_frame(v, 1'b1));
    end
    checks++;
    if (!cap_ok || cap_err_old !== 1'b0 || cap_err_new !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_set: got %b%b expected 01", cap_err_old, cap_err_new);
    end
    send(16'h0005, ok);
    capture_frame();
    pop_expected(v, sb_ok);
    checks++;
    if (!ok || !cap_ok || !sb_ok || cap_seg !== ref_frame(v, 1'b1)) begin
      errors++;
      $display("[TB] FAIL load_0005: got %h expected %h", cap_seg, ref_frame(v, 1'b1));
    end
    checks++;
    if (!cap_ok || cap_err_old !== 1'b1 || cap_err_new !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b%b expected 10", cap_err_old, cap_err_new);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, sb_ok;
    logic [15:0] v;
    send(16'h1111, ok1);
    fork
      send(16'h2222, ok2);
      begin
        capture_frame();
        pop_expected(v, sb_ok);
        checks++;
        if (!cap_ok || !sb_ok || v !== 16'h1111 || cap_seg !== ref_frame(16'h1111, 1'b1)) begin
          errors++;
          $display("[TB] FAIL b2b_first: got %h (q %h) expected %h",
                   cap_seg, v, ref_frame(16'h1111, 1'b1));
        end
        capture_frame();
        pop_expected(v, sb_ok);
        checks++;
        if (!cap_ok || !sb_ok || v !== 16'h2222 || cap_seg !== ref_frame(16'h2222, 1'b1)) begin
          errors++;
          $display("[TB] FAIL b2b_second: got %h (q %h) expected %h",
                   cap_seg, v, ref_frame(16'h2222, 1'b1));
        end
      end
    join
    checks++;
    if (!ok1 || !ok2) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got %b%b expected 11", ok1, ok2);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    bit ok, sb_ok;
    logic [15:0] v;
    n = 0;
    while (!(frame_done && in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_bcd = 16'h4321;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_accept: got rdy=%b expected 0", in_ready);
    end
    n = 1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_hold: got %0d cycles rdy=%b expected 16 rdy=0", n, in_ready);
    end
    capture_frame();
    pop_expected(v, sb_ok);
    checks++;
    if (!cap_ok || !sb_ok || cap_seg !== ref_frame(v, 1'b1) || cap_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_cycle_show: got %h rdy=%b expected %h rdy=1",
               cap_seg, cap_ready, ref_frame(v, 1'b1));
    end
    // Reset with pending full, then hold a handshake offer through reset.
    send(16'h5678, ok);
    rst = 1'b1;
    in_bcd = 16'h8888;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || seg !== 7'b0000000 || dig_en !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_pending: got rdy=%b seg=%b en=%b expected 1 0000000 0000",
               in_ready, seg, dig_en);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_over_handshake: got rdy=%b expected 1", in_ready);
    end
    capture_frame();
    checks++;
    if (!cap_ok || cap_seg !== ref_frame(16'h0000, 1'b1) || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_display: got %h q=%0d expected %h q=0",
               cap_seg, exp_q.size(), ref_frame(16'h0000, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_digits();
    test_blanking();
    test_err();
    test_back_to_back();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
